game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game-flow controller for the Super Mario VGA design. It sequences start screen, per-level screen draws, gameplay, pause, death and game-over. It generalises the fixed three-level flow to NUM_LEVELS levels and adds a lives counter, a timed death screen, pause/resume and win/game-over indication. It sits between the keyboard decoder, the level/collision logic and the VGA drawing engines.

## Interface

**Parameters**
- NUM_LEVELS, 3, number of playable levels (2..16)
- LVL_W, 2, width of level index; must satisfy 2^LVL_W >= NUM_LEVELS
- LIVES, 3, lives granted at game start (1..2^LIFE_W-1)
- LIFE_W, 2, width of lives counter
- DEATH_HOLD, 60, cycles spent in death screen (>= 1)

**Ports**
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spacebar  in  1  level-sensitive key; rising edge used
- pause_key  in  1  level-sensitive key; rising edge used
- level_done  in  1  current level completed (pipe/next/flag generalised), sampled in PLAY only
- dead  in  1  player death, sampled in PLAY only
- done  in  1  draw engine finished current screen
- start  out  1  start screen active
- draw  out  1  draw engine run request
- writeEn  out  1  framebuffer write enable
- level  out  LVL_W  current level index, 0-based
- lvl  out  NUM_LEVELS  one-hot level select, valid in PLAY/PAUSE, else 0
- timer_enable  out  1  game timer runs
- lives  out  LIFE_W  remaining lives
- gameover  out  1  game-over screen active
- win  out  1  one-cycle pulse on final-level completion

## Operation

- States: DRAW_START, START_SCREEN, DRAW_LEVEL, PLAY, PAUSE, DYING, GAME_OVER.
- Edge detect: spacebar and pause_key each have a previous-value register; edge = key & ~prev. Prev registers clear to 0 on reset.
- DRAW_START: draw=start=writeEn=1. done -> START_SCREEN.
- START_SCREEN: start=1. Spacebar edge -> DRAW_LEVEL; level<=0, lives<=LIVES.
- DRAW_LEVEL: draw=writeEn=1. done -> PLAY.
- PLAY: lvl[level]=1, timer_enable=1. Priority per cycle is dead > level_done > pause edge.
  - dead -> DYING; lives<=lives-1, saturating at 0.
  - level_done with level==NUM_LEVELS-1 -> DRAW_START; win pulses.
  - level_done otherwise -> DRAW_LEVEL; level<=level+1.
  - pause edge -> PAUSE.
- PAUSE: lvl held, timer_enable=0. Pause edge -> PLAY. dead and level_done are ignored.
- DYING: counter loads DEATH_HOLD-1 on entry and decrements each cycle. At 0: lives==0 -> GAME_OVER; otherwise -> DRAW_LEVEL, keeping the same level.
- GAME_OVER: gameover=1. Spacebar edge -> DRAW_START.
- dead, level_done and done are ignored in every state not listed as consuming them.
- All outputs not listed for a state are 0. lives and level hold their values outside the transitions above.

## Timing

- Reset values: state=DRAW_START, level=0, lives=LIVES, death counter=0, win=0.
- Reset output values: draw=start=writeEn=1; all other outputs 0 except lives=LIVES.
- Reset has priority over all inputs, including mid-draw, mid-death and PAUSE.
- Moore outputs decode the registered state. A transition input sampled at edge N changes outputs after edge N, i.e. one-cycle latency.
- win is registered. It is high exactly during the first DRAW_START cycle after final-level completion.
- DYING lasts exactly DEATH_HOLD cycles.
- A key held high produces one edge only. Re-triggering requires a low cycle.
- A spacebar edge in the same cycle the FSM enters START_SCREEN is not acted on; only edges sampled while in START_SCREEN count.
- done asserted in the same cycle the FSM enters DRAW_* is not acted on.

## Test plan

- Reset, done=1 for one cycle, then spacebar edge, then done -> path DRAW_START->START_SCREEN->DRAW_LEVEL->PLAY; level=0, lvl=001, lives=3, timer_enable=1.
- In PLAY, pulse level_done three times, each followed by done -> level advances 0->1->2; third pulse returns to DRAW_START with win=1 for exactly one cycle.
- DEATH_HOLD=4: dead in PLAY -> lives 3->2, DYING exactly 4 cycles, then DRAW_LEVEL with level unchanged.
- Three deaths -> lives=0, GAME_OVER with gameover=1; spacebar edge -> DRAW_START.
- pause_key held high 10 cycles in PLAY -> one PAUSE entry, timer_enable=0; dead=1 in PAUSE ignored; next pause edge -> PLAY.
- dead and level_done both high in PLAY -> DYING taken, level unchanged. Reset asserted in DYING -> DRAW_START, lives=3 on the next cycle.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the Super Mario VGA design: start screen, level draws,
// play/pause, timed death screen with a lives counter, and game-over.
module game_flow_ctrl #(
    parameter int NUM_LEVELS = 3,
    parameter int LVL_W      = 2,
    parameter int LIVES      = 3,
    parameter int LIFE_W     = 2,
    parameter int DEATH_HOLD = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spacebar,
    input  logic                  pause_key,
    input  logic                  level_done,
    input  logic                  dead,
    input  logic                  done,
    output logic                  start,
    output logic                  draw,
    output logic                  writeEn,
    output logic [LVL_W-1:0]      level,
    output logic [NUM_LEVELS-1:0] lvl,
    output logic                  timer_enable,
    output logic [LIFE_W-1:0]     lives,
    output logic                  gameover,
    output logic                  win
);

    localparam int CNT_W = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;

    typedef enum logic [2:0] {
        S_DRAW_START,
        S_START_SCREEN,
        S_DRAW_LEVEL,
        S_PLAY,
        S_PAUSE,
        S_DYING,
        S_GAME_OVER
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               space_prev;
    logic               pause_prev;
    logic               space_edge;
    logic               pause_edge;
    logic               last_level;
    logic [CNT_W-1:0]   death_cnt;

    assign space_edge = spacebar & ~space_prev;
    assign pause_edge = pause_key & ~pause_prev;
    assign last_level = (level == LVL_W'(NUM_LEVELS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_DRAW_START;
        end else begin
            state <= next_state;
        end
    end

    // Level, lives, death timer and win pulse only change on the FSM's own transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            space_prev <= 1'b0;
            pause_prev <= 1'b0;
            level      <= '0;
            lives      <= LIFE_W'(LIVES);
            death_cnt  <= '0;
            win        <= 1'b0;
        end else begin
            space_prev <= spacebar;
            pause_prev <= pause_key;
            win        <= 1'b0;
            case (state)
                S_START_SCREEN: begin
                    if (space_edge) begin
                        level <= '0;
                        lives <= LIFE_W'(LIVES);
                    end
                end
                S_PLAY: begin
                    if (dead) begin
                        if (lives != '0) begin
                            lives <= lives - LIFE_W'(1);
                        end
                        death_cnt <= CNT_W'(DEATH_HOLD - 1);
                    end else if (level_done) begin
                        if (last_level) begin
                            win <= 1'b1;
                        end else begin
                            level <= level + LVL_W'(1);
                        end
                    end
                end
                S_DYING: begin
                    if (death_cnt != '0) begin
                        death_cnt <= death_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_DRAW_START:   if (done) next_state = S_START_SCREEN;
            S_START_SCREEN: if (space_edge) next_state = S_DRAW_LEVEL;
            S_DRAW_LEVEL:   if (done) next_state = S_PLAY;
            S_PLAY: begin
                if (dead) begin
                    next_state = S_DYING;
                end else if (level_done) begin
                    next_state = last_level ? S_DRAW_START : S_DRAW_LEVEL;
                end else if (pause_edge) begin
                    next_state = S_PAUSE;
                end
            end
            S_PAUSE:        if (pause_edge) next_state = S_PLAY;
            S_DYING: begin
                if (death_cnt == '0) begin
                    next_state = (lives == '0) ? S_GAME_OVER : S_DRAW_LEVEL;
                end
            end
            S_GAME_OVER:    if (space_edge) next_state = S_DRAW_START;
            default:        next_state = S_DRAW_START;
        endcase
    end

    always_comb begin
        start        = 1'b0;
        draw         = 1'b0;
        writeEn      = 1'b0;
        timer_enable = 1'b0;
        gameover     = 1'b0;
        lvl          = '0;
        case (state)
            S_DRAW_START: begin
                start   = 1'b1;
                draw    = 1'b1;
                writeEn = 1'b1;
            end
            S_START_SCREEN: start = 1'b1;
            S_DRAW_LEVEL: begin
                draw    = 1'b1;
                writeEn = 1'b1;
            end
            S_PLAY, S_PAUSE: begin
                timer_enable = (state == S_PLAY);
                for (int i = 0; i < NUM_LEVELS; i++) begin
                    lvl[i] = (level == LVL_W'(i));
                end
            end
            S_GAME_OVER: gameover = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed walk through the game flow followed by random
// key/event traffic, every cycle compared against a screen-level reference model.
module tb_game_flow_ctrl;

    localparam int NUM_LEVELS = 3;
    localparam int LVL_W      = 2;
    localparam int LIVES      = 3;
    localparam int LIFE_W     = 2;
    localparam int DEATH_HOLD = 4;

    logic                  clk;
    logic                  reset;
    logic                  spacebar;
    logic                  pause_key;
    logic                  level_done;
    logic                  dead;
    logic                  done;
    logic                  start;
    logic                  draw;
    logic                  writeEn;
    logic [LVL_W-1:0]      level;
    logic [NUM_LEVELS-1:0] lvl;
    logic                  timer_enable;
    logic [LIFE_W-1:0]     lives;
    logic                  gameover;
    logic                  win;

    int errors = 0;
    int checks = 0;

    // Reference model: the screen currently shown plus the game bookkeeping.
    string mScreen;
    int    mLevel;
    int    mLives;
    int    mDyingLeft;
    int    mWin;
    int    mSpacePrev;
    int    mPausePrev;
    int    winPulses;

    game_flow_ctrl #(
        .NUM_LEVELS(NUM_LEVELS),
        .LVL_W(LVL_W),
        .LIVES(LIVES),
        .LIFE_W(LIFE_W),
        .DEATH_HOLD(DEATH_HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .spacebar(spacebar),
        .pause_key(pause_key),
        .level_done(level_done),
        .dead(dead),
        .done(done),
        .start(start),
        .draw(draw),
        .writeEn(writeEn),
        .level(level),
        .lvl(lvl),
        .timer_enable(timer_enable),
        .lives(lives),
        .gameover(gameover),
        .win(win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep(input int rst, input int sp, input int pk,
                             input int ld, input int dd, input int dn);
        int spEdge;
        int pkEdge;
        if (rst != 0) begin
            mScreen = "draw_start";
            mLevel = 0;
            mLives = LIVES;
            mDyingLeft = 0;
            mWin = 0;
            mSpacePrev = 0;
            mPausePrev = 0;
            return;
        end
        spEdge = (sp != 0 && mSpacePrev == 0) ? 1 : 0;
        pkEdge = (pk != 0 && mPausePrev == 0) ? 1 : 0;
        mWin = 0;
        if (mScreen == "draw_start") begin
            if (dn != 0) mScreen = "start_screen";
        end else if (mScreen == "start_screen") begin
            if (spEdge != 0) begin
                mScreen = "draw_level";
                mLevel = 0;
                mLives = LIVES;
            end
        end else if (mScreen == "draw_level") begin
            if (dn != 0) mScreen = "play";
        end else if (mScreen == "play") begin
            if (dd != 0) begin
                mLives = (mLives > 0) ? mLives - 1 : 0;
                mDyingLeft = DEATH_HOLD;
                mScreen = "dying";
            end else if (ld != 0) begin
                if (mLevel == NUM_LEVELS - 1) begin
                    mScreen = "draw_start";
                    mWin = 1;
                end else begin
                    mLevel = mLevel + 1;
                    mScreen = "draw_level";
                end
            end else if (pkEdge != 0) begin
                mScreen = "pause";
            end
        end else if (mScreen == "pause") begin
            if (pkEdge != 0) mScreen = "play";
        end else if (mScreen == "dying") begin
            mDyingLeft = mDyingLeft - 1;
            if (mDyingLeft == 0) mScreen = (mLives == 0) ? "game_over" : "draw_level";
        end else if (mScreen == "game_over") begin
            if (spEdge != 0) mScreen = "draw_start";
        end
        mSpacePrev = sp;
        mPausePrev = pk;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s at %0t (screen %s): observed=%0h expected=%0h",
                   tag, $time, mScreen, observed, expected);
        end
    endtask

    task automatic checkOutput();
        int onPlayfield;
        logic [31:0] expLvl;
        onPlayfield = (mScreen == "play" || mScreen == "pause") ? 1 : 0;
        expLvl = (onPlayfield != 0) ? (32'd1 << mLevel) : 32'd0;
        checkOne("start", 32'(start), 32'((mScreen == "draw_start" || mScreen == "start_screen") ? 1 : 0));
        checkOne("draw", 32'(draw), 32'((mScreen == "draw_start" || mScreen == "draw_level") ? 1 : 0));
        checkOne("writeEn", 32'(writeEn), 32'((mScreen == "draw_start" || mScreen == "draw_level") ? 1 : 0));
        checkOne("timer_enable", 32'(timer_enable), 32'((mScreen == "play") ? 1 : 0));
        checkOne("gameover", 32'(gameover), 32'((mScreen == "game_over") ? 1 : 0));
        checkOne("lvl", 32'(lvl), expLvl);
        checkOne("level", 32'(level), 32'(mLevel));
        checkOne("lives", 32'(lives), 32'(mLives));
        checkOne("win", 32'(win), 32'(mWin));
        if (win === 1'b1) winPulses++;
    endtask

    task automatic applyStimulus(input int rst, input int sp, input int pk,
                                 input int ld, input int dd, input int dn);
        reset      = (rst != 0);
        spacebar   = (sp != 0);
        pause_key  = (pk != 0);
        level_done = (ld != 0);
        dead       = (dd != 0);
        done       = (dn != 0);
        @(posedge clk);
        modelStep(rst, sp, pk, ld, dd, dn);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic enterPlayFromStart();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        mScreen = "draw_start";
        mLevel = 0;
        mLives = LIVES;
        mDyingLeft = 0;
        mWin = 0;
        mSpacePrev = 0;
        mPausePrev = 0;
        winPulses = 0;
        reset = 1'b1;
        spacebar = 1'b0;
        pause_key = 1'b0;
        level_done = 1'b0;
        dead = 1'b0;
        done = 1'b0;

        $display("[TB] reset and start path");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        idle(2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        enterPlayFromStart();
        checkOne("play_lvl_one_hot", 32'(lvl), 32'd1);
        checkOne("play_timer", 32'(timer_enable), 32'd1);

        $display("[TB] level progression and win");
        winPulses = 0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        idle(3);
        checkOne("win_pulse_count", 32'(winPulses), 32'd1);

        $display("[TB] deaths down to game over");
        applyStimulus(0, 0, 0, 0, 0, 1);
        enterPlayFromStart();
        for (int d = 0; d < LIVES; d++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            idle(DEATH_HOLD);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        checkOne("game_over_reached", 32'(gameover), 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOne("game_over_exit", 32'(start), 32'd1);

        $display("[TB] pause held, events ignored while paused");
        applyStimulus(0, 0, 0, 0, 0, 1);
        enterPlayFromStart();
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] dead beats level_done, reset during dying");
        applyStimulus(0, 0, 0, 1, 1, 0);
        idle(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("reset_lives", 32'(lives), 32'(LIVES));
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0) ? 1 : 0,
                          ($urandom_range(0, 3) == 0) ? 1 : 0,
                          ($urandom_range(0, 5) == 0) ? 1 : 0,
                          ($urandom_range(0, 9) == 0) ? 1 : 0,
                          ($urandom_range(0, 14) == 0) ? 1 : 0,
                          ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
